// File: rtl/le_r_offset_round_sat.sv
// Two-stage r-offset post-processor: round the slope x coordinate product,
// add the per-hit base offset, then saturate to the output width.
module le_r_offset_round_sat #(
  parameter int PROD_WIDTH = 33,
  parameter int SHIFT      = 12,
  parameter int OFF_WIDTH  = 18,
  parameter int DOUT_WIDTH = 18,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PROD_WIDTH-1:0] i_prod,
  input  logic [OFF_WIDTH-1:0]  i_offset,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic                  i_valid,
  output logic                  o_in_ready,
  output logic [DOUT_WIDTH-1:0] o_r_offset,
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic                  o_sat,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  input  logic                  i_cnt_clr,
  output logic [15:0]           o_sat_cnt
);

  localparam int R1W  = PROD_WIDTH - SHIFT + 1;
  localparam int SUMW = ((R1W > OFF_WIDTH) ? R1W : OFF_WIDTH) + 1;

  localparam logic signed [PROD_WIDTH:0] RND = (PROD_WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic signed [SUMW-1:0] SAT_MAX =
    {{(SUMW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUMW-1:0] SAT_MIN =
    {{(SUMW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic                         en;
  logic signed [PROD_WIDTH:0]   prod_rnd;
  logic signed [R1W-1:0]        r1_d, r1_q;
  logic signed [OFF_WIDTH-1:0]  off1_q;
  logic [TAG_WIDTH-1:0]         tag1_q, tag2_q;
  logic                         v1_q, v2_q;
  logic signed [SUMW-1:0]       sum;
  logic [DOUT_WIDTH-1:0]        dout_d, dout_q;
  logic                         sat_d, sat_q;
  logic [15:0]                  cnt_d, cnt_q;

  assign en = !v2_q | i_out_ready;
  // During reset the output stage reads as empty, so the block looks ready.
  assign o_in_ready = en | reset;

  // One extra bit of headroom keeps the rounding add from overflowing.
  assign prod_rnd = $signed({i_prod[PROD_WIDTH-1], i_prod}) + RND;
  assign r1_d     = R1W'(prod_rnd >>> SHIFT);

  assign sum = SUMW'(r1_q) + SUMW'(off1_q);

  always_comb begin
    dout_d = sum[DOUT_WIDTH-1:0];
    sat_d  = 1'b0;
    if (sum > SAT_MAX) begin
      dout_d = SAT_MAX[DOUT_WIDTH-1:0];
      sat_d  = 1'b1;
    end else if (sum < SAT_MIN) begin
      dout_d = SAT_MIN[DOUT_WIDTH-1:0];
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      r1_q   <= '0;
      off1_q <= '0;
      tag1_q <= '0;
      v2_q   <= 1'b0;
      dout_q <= '0;
      tag2_q <= '0;
      sat_q  <= 1'b0;
    end else if (en) begin
      v1_q   <= i_valid;
      r1_q   <= r1_d;
      off1_q <= $signed(i_offset);
      tag1_q <= i_tag;
      v2_q   <= v1_q;
      dout_q <= dout_d;
      tag2_q <= tag1_q;
      sat_q  <= sat_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr)
      cnt_d = '0;
    else if (v2_q && i_out_ready && sat_q && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_valid    = v2_q;
  assign o_r_offset = dout_q;
  assign o_tag      = tag2_q;
  assign o_sat      = sat_q;
  assign o_sat_cnt  = cnt_q;

endmodule

// File: tb/tb_le_r_offset_round_sat.sv
// Scoreboard bench: driver pushes model results on acceptance, monitor pops on
// each output handshake and also tracks the saturation counter.
module tb_le_r_offset_round_sat;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [32:0] i_prod = '0;
  logic [17:0] i_offset = '0;
  logic [7:0]  i_tag = '0;
  logic        i_valid = 1'b0;
  logic        o_in_ready;
  logic [17:0] o_r_offset;
  logic [7:0]  o_tag;
  logic        o_sat;
  logic        o_valid;
  logic        i_out_ready = 1'b1;
  logic        i_cnt_clr = 1'b0;
  logic [15:0] o_sat_cnt;

  le_r_offset_round_sat dut (
    .clk(clk), .reset(reset), .i_prod(i_prod), .i_offset(i_offset), .i_tag(i_tag),
    .i_valid(i_valid), .o_in_ready(o_in_ready), .o_r_offset(o_r_offset), .o_tag(o_tag),
    .o_sat(o_sat), .o_valid(o_valid), .i_out_ready(i_out_ready), .i_cnt_clr(i_cnt_clr),
    .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint     r;
    bit         s;
    logic [7:0] tag;
    int         acc_edge;
    int         stall_at;
  } item_t;

  item_t  sb[$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     edge_idx = 0;
  int     stall_total = 0;
  longint cnt_model = 0;
  bit     armed = 0;
  bit     prev_rst = 0;
  bit     hold_pending = 0;
  logic [26:0] held;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_idx);
    end
  endtask

  // Round half up to an integer, add offset, clamp to 18-bit signed.
  function automatic void ref_model(input logic [32:0] p, input logic [17:0] o,
                                    output longint r, output bit s);
    longint t, q, sum;
    t = longint'($signed(p)) + 2048;
    q = t / 4096;
    if ((t % 4096) != 0 && t < 0) q = q - 1;
    sum = q + longint'($signed(o));
    s = 1'b0;
    r = sum;
    if (sum > 131071)  begin r = 131071;  s = 1'b1; end
    if (sum < -131072) begin r = -131072; s = 1'b1; end
  endfunction

  task automatic drive(input bit v, input logic [32:0] p, input logic [17:0] o,
                       input logic [7:0] t, input bit rdy, input bit clr, input bit rst,
                       input bit use_exp, input longint er, input bit es, output bit acc);
    item_t it;
    @(negedge clk);
    i_valid = v; i_prod = p; i_offset = o; i_tag = t;
    i_out_ready = rdy; i_cnt_clr = clr; reset = rst;
    #1;
    acc = v && o_in_ready && !rst;
    if (use_exp) begin it.r = er; it.s = es; end
    else ref_model(p, o, it.r, it.s);
    it.tag = t;
    it.acc_edge = edge_idx;
    it.stall_at = stall_total;
    @(posedge clk);
    if (rst) sb.delete();
    if (acc) sb.push_back(it);
  endtask

  always @(negedge clk) begin
    item_t it;
    longint cnt_next;
    #2;
    cnt_next = cnt_model;
    if (armed) begin
      check(o_in_ready == (reset || !o_valid || i_out_ready), "in_ready", o_in_ready, !o_valid || i_out_ready);
      check(o_sat_cnt == cnt_model[15:0], "sat_cnt", o_sat_cnt, cnt_model);
      if (prev_rst) check(o_valid == 1'b0, "valid_after_reset", o_valid, 0);
      if (hold_pending)
        check({o_r_offset, o_tag, o_sat} == held, "hold_stable", {o_r_offset, o_tag, o_sat}, held);
      if (!reset && o_valid && i_out_ready) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_beat", o_tag, -1);
        end else begin
          it = sb.pop_front();
          check(longint'($signed(o_r_offset)) == it.r, "r_offset", $signed(o_r_offset), it.r);
          check(o_tag == it.tag, "tag", o_tag, it.tag);
          check(o_sat == it.s, "sat", o_sat, it.s);
          check(edge_idx == it.acc_edge + 2 + (stall_total - it.stall_at), "latency",
                edge_idx - it.acc_edge, 2 + (stall_total - it.stall_at));
          if (it.s && cnt_model != 65535) cnt_next = cnt_model + 1;
        end
      end
      if (i_cnt_clr) cnt_next = 0;
    end
    if (reset) cnt_next = 0;
    hold_pending = !reset && o_valid && !i_out_ready;
    held = {o_r_offset, o_tag, o_sat};
    if (hold_pending) stall_total++;
    cnt_model = cnt_next;
    prev_rst = reset;
    if (reset) armed = 1'b1;
    edge_idx++;
  end

  bit acc;
  logic [63:0] rnd64;
  longint pv;
  logic [32:0] rp;
  int idx;

  initial begin
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, acc);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, acc);

    // Directed values with hand-derived expectations.
    drive(1, 33'd6144, 18'd5, 8'h11, 1, 0, 0, 1, 7, 0, acc);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, acc);
    drive(1, -33'sd6144, 18'd0, 8'h21, 1, 0, 0, 1, -1, 0, acc);
    drive(1, 33'd2048, 18'd0, 8'h22, 1, 0, 0, 1, 1, 0, acc);
    drive(1, 33'd2047, 18'd0, 8'h23, 1, 0, 0, 1, 0, 0, acc);
    drive(1, 33'h0_8000_0000, 18'd0, 8'h31, 1, 0, 0, 1, 131071, 1, acc);
    drive(1, 33'h1_0000_0000, -18'sd5, 8'h32, 1, 0, 0, 1, -131072, 1, acc);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, acc);

    // Tags 1..4 streamed, output stalled for 3 cycles once the first emerges.
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      drive(1, 33'(4096 * (idx + 1)), 18'd100, 8'(idx + 1), !(c >= 2 && c <= 4), 0, 0, 0, 0, 0, acc);
      if (acc) idx++;
    end
    check(idx == 4, "stream_accept", idx, 4);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, acc);

    // Reset with two beats in flight; neither may appear.
    drive(1, 33'd8192, 18'd1, 8'h41, 1, 0, 0, 0, 0, 0, acc);
    drive(1, 33'd8192, 18'd2, 8'h42, 1, 0, 0, 0, 0, 0, acc);
    drive(1, 33'd8192, 18'd3, 8'h43, 0, 0, 1, 0, 0, 0, acc);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, acc);

    // Drive the counter to its ceiling, then clear during a saturating handshake.
    for (int i = 0; i < 65540; i++)
      drive(1, 33'h0_8000_0000, 18'd0, 8'(i), 1, 0, 0, 0, 0, 0, acc);
    drive(1, 33'h0_8000_0000, 18'd0, 8'h55, 1, 1, 0, 0, 0, 0, acc);
    for (int i = 0; i < 3; i++)
      drive(1, 33'h1_0000_0000, 18'd0, 8'h56, 1, 0, 0, 0, 0, 0, acc);

    // Randomized traffic with backpressure and occasional clears.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(3))
        0: pv = longint'($urandom_range(40000)) - 20000;
        1: begin rnd64 = {$urandom, $urandom}; pv = longint'($signed(rnd64[32:0])); end
        2: pv = (($urandom_range(1) == 1) ? 536870912 : -536870912) + longint'($urandom_range(2097152)) - 1048576;
        default: pv = (longint'($urandom_range(2000)) - 1000) * 2048 + longint'($urandom_range(2)) - 1;
      endcase
      rp = pv[32:0];
      drive($urandom_range(9) < 7, rp, 18'($urandom), 8'($urandom), $urandom_range(9) < 7,
            $urandom_range(49) == 0, 0, 0, 0, 0, acc);
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, acc);
    check(sb.size() == 0, "drain", sb.size(), 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/le_r_offset_round_sat.md
LE_R_OFFSET_ROUND_SAT -- requirements
Module: le_r_offset_round_sat

Interface
REQ-001 Parameters SHALL be (name, default, meaning): PROD_WIDTH, 33, signed product width from r-offset multiplier.
REQ-002 SHIFT, 12, fractional bits removed by rounding; OFF_WIDTH, 18, signed base-offset width; DOUT_WIDTH, 18, signed result width; TAG_WIDTH, 8, hit tag width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 i_prod  in  PROD_WIDTH  signed product (slope x coordinate) from multiplier stage.
REQ-006 i_offset  in  OFF_WIDTH  signed base r-offset for this hit.
REQ-007 i_tag  in  TAG_WIDTH  hit identifier, carried unchanged.
REQ-008 i_valid  in  1  input beat valid.
REQ-009 o_in_ready  out  1  block accepts input this cycle; drives multiplier ce.
REQ-010 o_r_offset  out  DOUT_WIDTH  signed rounded, offset, saturated result.
REQ-011 o_tag  out  TAG_WIDTH  tag of o_r_offset.
REQ-012 o_sat  out  1  result was clamped.
REQ-013 o_valid  out  1  output beat valid.
REQ-014 i_out_ready  in  1  downstream accepts output.
REQ-015 i_cnt_clr  in  1  clear saturation counter.
REQ-016 o_sat_cnt  out  16  saturating count of clamped results.

Function
REQ-017 Pipeline SHALL have two register stages (S1 round, S2 offset+saturate); advance enable en = !o_valid | i_out_ready.
REQ-018 o_in_ready SHALL equal en (combinational); input accepted when i_valid & en.
REQ-019 Latency SHALL be exactly 2 clk cycles from acceptance to o_valid with i_out_ready held high; throughput 1 beat/cycle.
REQ-020 When en=0 all stage registers, including valid bits, SHALL hold; no beat dropped, duplicated or reordered.
REQ-021 Bubbles SHALL propagate as invalid stages; o_valid low with en high advances the pipe.
REQ-022 S1: r1 = (sext(i_prod,PROD_WIDTH+1) + 2^(SHIFT-1)) >>> SHIFT (arithmetic; round half toward +inf), width PROD_WIDTH-SHIFT+1, no overflow.
REQ-023 S2: sum = r1 + sext(offset), computed at max(width r1, OFF_WIDTH)+1 bits, no intermediate overflow.
REQ-024 sum > 2^(DOUT_WIDTH-1)-1 SHALL yield max positive, o_sat=1; sum < -2^(DOUT_WIDTH-1) SHALL yield most negative, o_sat=1; else sum, o_sat=0.
REQ-025 i_tag SHALL travel with its data through both stages.
REQ-026 o_sat_cnt SHALL increment by 1 on each output handshake (o_valid & i_out_ready) with o_sat=1; holds at 0xFFFF.
REQ-027 i_cnt_clr SHALL zero o_sat_cnt next cycle; clear wins over a simultaneous increment.
REQ-028 o_r_offset/o_tag/o_sat SHALL be stable while o_valid=1 and i_out_ready=0.

Reset
REQ-029 reset SHALL clear both stage valids, o_valid, o_r_offset, o_tag, o_sat and o_sat_cnt to 0 on the next edge, overriding en and i_cnt_clr.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; first beat accepted after reset deasserts emerges 2 cycles later.
REQ-031 During reset o_in_ready SHALL equal en evaluated with o_valid=0 (i.e., 1); inputs sampled in the reset cycle are discarded.

Verification (defaults)
REQ-032 i_prod=6144, i_offset=5, tag=0x11, i_out_ready=1 -> 2 cycles later o_r_offset=7, o_tag=0x11, o_sat=0.
REQ-033 i_prod=-6144, offset=0 -> o_r_offset=-1; i_prod=2048 -> 1; i_prod=2047 -> 0.
REQ-034 i_prod=2^31, offset=0 -> o_r_offset=131071, o_sat=1, o_sat_cnt=1; i_prod=-2^32, offset=-5 -> -131072, o_sat=1, cnt=2.
REQ-035 Stream tags 1..4 back-to-back, i_out_ready low 3 cycles after first o_valid -> o_in_ready low those cycles, outputs held, tags 1..4 delivered in order, none lost.
REQ-036 Reset asserted with 2 beats in flight -> o_valid=0 next cycle, o_sat_cnt=0, neither beat ever emitted.
REQ-037 Preload o_sat_cnt=0xFFFF, another saturating beat -> stays 0xFFFF; i_cnt_clr with simultaneous saturating handshake -> 0.
